fetch_redirect_ctrl: RTL and testbench

- Sequences the fetch-stage program counter register.
- Arbitrates PC redirect sources: trap, EX branch/jump resolution, decode stall, instruction-memory wait and halt.
- Drives the PC register's redirect/target/hold inputs and the F/D flush lines.
- Buffers a redirect that arrives while an instruction fetch is outstanding, and replays it when memory accepts.

---
 rtl/fetch_redirect_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl
//   Controls the fetch-stage PC register. It picks one redirect source per
//   cycle, in priority order trap > EX branch/jump > buffered redirect >
//   stall/imem wait > sequential fetch. A redirect that arrives while an
//   instruction fetch is still outstanding (imem_ready=0) is parked in
//   pend_pc. It is replayed on the cycle memory accepts.
//
// Optional feature: define FETCH_REDIRECT_STATS_EN to add the
//   cnt_redirect / cnt_wait / cnt_drop event counters (32-bit, wrapping).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   trap_valid/use_vec/pc     trap request; target is TRAP_VEC or trap_pc
//   EX_taken, EX_alt_pc       branch/jump redirect resolved in EX
//   stall_D                   decode hazard stall
//   imem_ready                instruction memory accepts/returns this cycle
//   halt_req, resume          enter / leave HALT
//   pc_redirect, pc_target    PC register loads pc_target (zero-latency)
//   pc_hold                   PC register holds its value
//   flush_F, flush_D          kill the instruction in F / D
//   pend_valid                a buffered redirect is outstanding
//   state                     00 RUN, 01 WAIT, 10 HALT
module fetch_redirect_ctrl #(
    parameter int               PCLEN    = 32,
    parameter logic [PCLEN-1:0] TRAP_VEC = PCLEN'(32'h100)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trap_valid,
    input  logic             trap_use_vec,
    input  logic [PCLEN-1:0] trap_pc,
    input  logic             EX_taken,
    input  logic [PCLEN-1:0] EX_alt_pc,
    input  logic             stall_D,
    input  logic             imem_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_redirect,
    output logic [PCLEN-1:0] pc_target,
    output logic             pc_hold,
    output logic             flush_F,
    output logic             flush_D,
    output logic             pend_valid,
    output logic [1:0]       state
`ifdef FETCH_REDIRECT_STATS_EN
    ,
    output logic [31:0]      cnt_redirect,
    output logic [31:0]      cnt_wait,
    output logic [31:0]      cnt_drop
`endif
);

    typedef enum logic [1:0] {
        S_RUN  = 2'b00,
        S_WAIT = 2'b01,
        S_HALT = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic             pend_valid_q, pend_valid_d;
    logic [PCLEN-1:0] pend_pc_q, pend_pc_d;

    logic             acc_new;   // a trap/EX redirect accepted this cycle
    logic             drop;      // an EX redirect discarded this cycle
    logic             have;      // something to redirect to
    logic [PCLEN-1:0] new_tgt, win_tgt;
    logic             redir_c, hold_c, ff_c, fd_c;
    logic [PCLEN-1:0] tgt_c;

    always_comb begin
        acc_new = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            S_RUN:  acc_new = trap_valid | EX_taken;
            // Once a redirect is parked, the younger EX instruction was
            // already flushed, so its branch outcome is stale.
            S_WAIT: begin
                acc_new = trap_valid | (EX_taken & ~pend_valid_q);
                drop    = EX_taken & pend_valid_q;
            end
            S_HALT: begin
                acc_new = trap_valid;
                drop    = EX_taken;
            end
            default: acc_new = 1'b0;
        endcase

        new_tgt = trap_valid ? (trap_use_vec ? TRAP_VEC : trap_pc) : EX_alt_pc;
        have    = acc_new | pend_valid_q;
        win_tgt = acc_new ? new_tgt : pend_pc_q;

        redir_c      = 1'b0;
        tgt_c        = '0;
        hold_c       = 1'b0;
        ff_c         = 1'b0;
        fd_c         = 1'b0;
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;

        if (state_q == S_HALT && !resume) begin
            hold_c = 1'b1;
            if (acc_new) begin
                pend_valid_d = 1'b1;
                pend_pc_d    = new_tgt;
                ff_c         = 1'b1;
                fd_c         = 1'b1;
            end
        end else if (have && imem_ready) begin
            // Apply now; F always dies, D only for a freshly accepted source
            // (a replayed redirect already flushed D when it was parked).
            redir_c      = 1'b1;
            tgt_c        = win_tgt;
            ff_c         = 1'b1;
            fd_c         = acc_new;
            pend_valid_d = 1'b0;
            state_d      = S_RUN;
        end else if (have) begin
            hold_c  = 1'b1;
            state_d = S_WAIT;
            if (acc_new) begin
                pend_valid_d = 1'b1;
                pend_pc_d    = new_tgt;
                ff_c         = 1'b1;
                fd_c         = 1'b1;
            end
        end else if (!imem_ready) begin
            hold_c  = 1'b1;
            state_d = S_WAIT;
        end else if (state_q == S_RUN && halt_req) begin
            hold_c  = 1'b1;
            state_d = S_HALT;
        end else begin
            hold_c  = stall_D;
            state_d = S_RUN;
        end

        // Outputs read as idle while reset is asserted.
        if (rst) begin
            redir_c = 1'b0;
            tgt_c   = '0;
            hold_c  = 1'b0;
            ff_c    = 1'b0;
            fd_c    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RUN;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign pc_redirect = redir_c;
    assign pc_target   = tgt_c;
    assign pc_hold     = hold_c;
    assign flush_F     = ff_c;
    assign flush_D     = fd_c;
    assign pend_valid  = pend_valid_q;
    assign state       = state_q;

`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0] cnt_redirect_q, cnt_wait_q, cnt_drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_redirect_q <= '0;
            cnt_wait_q     <= '0;
            cnt_drop_q     <= '0;
        end else begin
            cnt_redirect_q <= cnt_redirect_q + {31'd0, redir_c};
            cnt_wait_q     <= cnt_wait_q + {31'd0, (state_q == S_WAIT)};
            cnt_drop_q     <= cnt_drop_q + {31'd0, drop};
        end
    end

    assign cnt_redirect = cnt_redirect_q;
    assign cnt_wait     = cnt_wait_q;
    assign cnt_drop     = cnt_drop_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
module tb_fetch_redirect_ctrl;

    logic        clk;
    logic        rst;
    logic        trap_valid, trap_use_vec;
    logic [31:0] trap_pc;
    logic        EX_taken;
    logic [31:0] EX_alt_pc;
    logic        stall_D, imem_ready, halt_req, resume;
    logic        pc_redirect, pc_hold, flush_F, flush_D, pend_valid;
    logic [31:0] pc_target;
    logic [1:0]  state;
`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0] cnt_redirect, cnt_wait, cnt_drop;
`endif

    fetch_redirect_ctrl dut (
        .clk(clk), .rst(rst),
        .trap_valid(trap_valid), .trap_use_vec(trap_use_vec), .trap_pc(trap_pc),
        .EX_taken(EX_taken), .EX_alt_pc(EX_alt_pc),
        .stall_D(stall_D), .imem_ready(imem_ready),
        .halt_req(halt_req), .resume(resume),
        .pc_redirect(pc_redirect), .pc_target(pc_target), .pc_hold(pc_hold),
        .flush_F(flush_F), .flush_D(flush_D),
        .pend_valid(pend_valid), .state(state)
`ifdef FETCH_REDIRECT_STATS_EN
        , .cnt_redirect(cnt_redirect), .cnt_wait(cnt_wait), .cnt_drop(cnt_drop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the fetch mode plus a queue holding at most one
    // parked redirect target.
    localparam int RUN = 0, WAITM = 1, HALTM = 2;
    int          mode, mode_nx;
    logic [31:0] parked[$];
    logic [31:0] parked_nx[$];
    int unsigned m_redir, m_wait, m_drop, m_redir_nx, m_wait_nx, m_drop_nx;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock cycle: commit the model, drive inputs, then compare at mid-cycle.
    task automatic step(input bit r, input bit tv, input bit tu, input logic [31:0] tp,
                        input bit ex, input logic [31:0] ea, input bit st,
                        input bit rdy, input bit h, input bit rs);
        bit          e_r, e_h, e_ff, e_fd, fresh, dropped;
        logic [31:0] e_t, ftgt;
        @(posedge clk);
        mode = mode_nx; parked = parked_nx;
        m_redir = m_redir_nx; m_wait = m_wait_nx; m_drop = m_drop_nx;
        #1;
        rst = r; trap_valid = tv; trap_use_vec = tu; trap_pc = tp;
        EX_taken = ex; EX_alt_pc = ea; stall_D = st; imem_ready = rdy;
        halt_req = h; resume = rs;
        #3;
        e_r = 0; e_h = 0; e_ff = 0; e_fd = 0; e_t = 0;
        mode_nx = mode; parked_nx = parked;
        // An EX redirect counts only in RUN, or in WAIT before anything is parked.
        fresh   = tv || (ex && (mode == RUN || (mode == WAITM && parked.size() == 0)));
        dropped = ex && (mode == HALTM || (mode == WAITM && parked.size() != 0));
        ftgt    = tv ? (tu ? 32'h100 : tp) : ea;
        if (r) begin
            mode_nx = RUN; parked_nx = {};
            m_redir_nx = 0; m_wait_nx = 0; m_drop_nx = 0;
        end else begin
            m_wait_nx = m_wait + ((mode == WAITM) ? 1 : 0);
            m_drop_nx = m_drop + (dropped ? 1 : 0);
            if (mode == HALTM && !rs) begin
                e_h = 1;
                if (fresh) begin parked_nx = {ftgt}; e_ff = 1; e_fd = 1; end
            end else if ((fresh || parked.size() != 0) && rdy) begin
                e_r = 1; e_t = fresh ? ftgt : parked[0];
                e_ff = 1; e_fd = fresh;
                parked_nx = {}; mode_nx = RUN;
            end else if (fresh || parked.size() != 0) begin
                e_h = 1; mode_nx = WAITM;
                if (fresh) begin parked_nx = {ftgt}; e_ff = 1; e_fd = 1; end
            end else if (!rdy) begin
                e_h = 1; mode_nx = WAITM;
            end else if (mode == RUN && h) begin
                e_h = 1; mode_nx = HALTM;
            end else begin
                e_h = st; mode_nx = RUN;
            end
            m_redir_nx = m_redir + (e_r ? 1 : 0);
        end
        chk("m_redirect", {31'd0, pc_redirect}, {31'd0, e_r});
        chk("m_target", pc_target, e_t);
        chk("m_hold", {31'd0, pc_hold}, {31'd0, e_h});
        chk("m_flushF", {31'd0, flush_F}, {31'd0, e_ff});
        chk("m_flushD", {31'd0, flush_D}, {31'd0, e_fd});
        chk("m_pend", {31'd0, pend_valid}, {31'd0, parked.size() != 0});
        chk("m_state", {30'd0, state}, mode);
`ifdef FETCH_REDIRECT_STATS_EN
        chk("m_cnt_redirect", cnt_redirect, m_redir);
        chk("m_cnt_wait", cnt_wait, m_wait);
        chk("m_cnt_drop", cnt_drop, m_drop);
`endif
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, 0, 0, 0, rdy, 0, 0);
    endtask

    initial begin
        mode_nx = RUN; parked_nx = {};
        m_redir_nx = 0; m_wait_nx = 0; m_drop_nx = 0;
        rst = 1; trap_valid = 0; trap_use_vec = 0; trap_pc = 0; EX_taken = 0;
        EX_alt_pc = 0; stall_D = 0; imem_ready = 1; halt_req = 0; resume = 0;

        // Reset held: everything reads zero.
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 32'h44, 1, 32'h88, 0, 1, 0, 0);
        chk("rst_redirect", {31'd0, pc_redirect}, 0);
        chk("rst_state", {30'd0, state}, 0);
        chk("rst_pend", {31'd0, pend_valid}, 0);

        for (int i = 0; i < 4; i++) idle(1);
        chk("idle_hold", {31'd0, pc_hold}, 0);

        // EX redirect with memory ready: same-cycle redirect.
        step(0, 0, 0, 0, 1, 32'h40, 0, 1, 0, 0);
        chk("ex40_redirect", {31'd0, pc_redirect}, 1);
        chk("ex40_target", pc_target, 32'h40);
        chk("ex40_flushD", {31'd0, flush_D}, 1);
        idle(1);
        chk("ex40_after", {31'd0, pc_redirect}, 0);

        // EX redirect during an outstanding fetch: parked, then replayed.
        step(0, 0, 0, 0, 1, 32'h80, 0, 0, 0, 0);
        chk("ex80_hold", {31'd0, pc_hold}, 1);
        idle(0);
        chk("ex80_state", {30'd0, state}, 1);
        chk("ex80_pend", {31'd0, pend_valid}, 1);
        idle(0);
        idle(1);
        chk("ex80_redirect", {31'd0, pc_redirect}, 1);
        chk("ex80_target", pc_target, 32'h80);
        idle(1);
        chk("ex80_state_run", {30'd0, state}, 0);
        chk("ex80_pend_clr", {31'd0, pend_valid}, 0);

        // Trap overwrites a parked EX target; later EX in WAIT is dropped.
        step(0, 0, 0, 0, 1, 32'h80, 0, 0, 0, 0);
        step(0, 1, 1, 32'h7777, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h999, 0, 0, 0, 0);
        chk("drop_flushD", {31'd0, flush_D}, 0);
        idle(1);
        chk("vec_target", pc_target, 32'h100);

        // Trap beats EX in the same cycle.
        step(0, 1, 0, 32'h200, 1, 32'h300, 0, 1, 0, 0);
        chk("prio_target", pc_target, 32'h200);

        // Halt, trap captured, resume replays it.
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("halt_hold", {31'd0, pc_hold}, 1);
        step(0, 1, 0, 32'h500, 1, 32'h600, 0, 1, 0, 0);
        chk("halt_state", {30'd0, state}, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        chk("resume_target", pc_target, 32'h500);
        idle(1);
        chk("resume_state", {30'd0, state}, 0);

        // Reset in the middle of WAIT drops the parked redirect.
        step(0, 0, 0, 0, 1, 32'hA0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("rstwait_pend", {31'd0, pend_valid}, 0);
        chk("rstwait_redirect", {31'd0, pc_redirect}, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 1) == 1,
                 $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 99) < 20, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 30);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
